// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
//   fetch_state_t : fetch FSM state encoding
//   ADDR_W/DATA_W : default program address and instruction widths
//   NOP_INSTR     : instruction the downstream bubble logic injects
package cpu_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// IF/ID handshake between the fetch stage and the decode stage.
//   valid : head entry is valid (master -> slave)
//   ready : decode accepts the head (slave -> master)
//   instr : head instruction
//   pc    : word address of the head instruction
interface fetch_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO.
//   push_i/push_data_i : write an entry (ignored when full unless popping)
//   pop_i              : drop the head entry (ignored when empty)
//   flush_i            : empty the queue; overrides push and pop
//   head_o             : head entry, count_o occupancy, empty_o/full_o flags
module fetch_queue #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             push_data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the asynchronous program SRAM
// with WAIT_CYCLES extra OE cycles per word, and prefetches into a queue
// whose head is offered to IF/ID.
//   clk, rst          : clock, async active-low reset
//   redirect(_pc)     : jump/branch target load, flushes queue, aborts read
//   ext_busy          : data side wants the SRAM bus
//   fetch_idle        : fetch is not driving the SRAM
//   out_if (master)   : {instr, pc} valid/ready handshake to IF/ID
//   sram_*            : SRAM address/control; data bus is input-only here
//
// state | meaning
// IDLE  | SRAM released (OE/EN high), waiting for room and a free bus
// READ  | OE/EN low on sram_addr; word sampled when the wait count hits 0
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW          = ADDR_W,
  parameter int unsigned DW          = DATA_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          ext_busy,
  output logic          fetch_idle,
  fetch_if.master       out_if,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_en_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);
  localparam int unsigned   QW = AW + DW;

  fetch_state_t            state_q;
  logic [AW-1:0]           pc_q;
  logic [CW-1:0]           wait_q;
  logic [AW-1:0]           sram_addr_q;
  logic                    sram_oe_n_q;
  logic                    sram_en_n_q;
  logic                    fetch_idle_q;

  logic [QW-1:0]           q_head;
  logic [$clog2(DEPTH):0]  q_count;
  logic                    q_empty;
  logic                    q_full;
  logic                    read_done;
  logic                    start_idle;
  logic                    start_chain;
  logic                    pop;

  assign sram_data = {DW{1'bz}};
  assign sram_we_n = 1'b1;

  assign sram_addr  = sram_addr_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_en_n  = sram_en_n_q;
  assign fetch_idle = fetch_idle_q;

  assign read_done = (state_q == READ) && (wait_q == '0) && !redirect;

  // Occupancy is the registered count: a same-edge pop gives no credit, and a
  // back-to-back read must also leave room for the word pushed on this edge.
  assign start_idle  = !redirect && !ext_busy && !q_full;
  assign start_chain = !redirect && !ext_busy && ((int'(q_count) + 1) < int'(DEPTH));

  assign pop = !q_empty && out_if.ready;

  fetch_queue #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (read_done),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_data_i ({sram_data, pc_q}),
    .head_o      (q_head),
    .count_o     (q_count),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

  assign out_if.valid = !q_empty;
  assign out_if.instr = q_head[QW-1:AW];
  assign out_if.pc    = q_head[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= AW'(RESET_PC);
      wait_q       <= '0;
      sram_addr_q  <= '0;
      sram_oe_n_q  <= 1'b1;
      sram_en_n_q  <= 1'b1;
      fetch_idle_q <= 1'b1;
    end else if (redirect) begin
      // Abort: the in-flight word is dropped because read_done is gated off.
      state_q      <= IDLE;
      pc_q         <= redirect_pc;
      wait_q       <= '0;
      sram_oe_n_q  <= 1'b1;
      sram_en_n_q  <= 1'b1;
      fetch_idle_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_idle) begin
            state_q      <= READ;
            sram_addr_q  <= pc_q;
            wait_q       <= WAIT_LD;
            sram_oe_n_q  <= 1'b0;
            sram_en_n_q  <= 1'b0;
            fetch_idle_q <= 1'b0;
          end
        end
        READ: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end else begin
            pc_q <= pc_q + 1'b1;
            if (start_chain) begin
              sram_addr_q <= pc_q + 1'b1;
              wait_q      <= WAIT_LD;
            end else begin
              state_q      <= IDLE;
              sram_oe_n_q  <= 1'b1;
              sram_en_n_q  <= 1'b1;
              fetch_idle_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          sram_oe_n_q  <= 1'b1;
          sram_en_n_q  <= 1'b1;
          fetch_idle_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [17:0] redirect_pc = '0;
  logic        ext_busy = 1'b0;
  logic        zero_special = 1'b0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // main instance: RESET_PC = 0
  fetch_if #(.AW(18), .DW(16)) fif ();
  logic        fetch_idle;
  logic [17:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_oe_n, sram_we_n, sram_en_n;

  fetch_unit #(.AW(18), .DW(16), .DEPTH(4), .WAIT_CYCLES(1), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .ext_busy(ext_busy), .fetch_idle(fetch_idle), .out_if(fif),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_en_n(sram_en_n)
  );

  assign sram_data = (!sram_oe_n && !sram_en_n)
                   ? ((zero_special && sram_addr == 18'd0) ? 16'h0800 : 16'h1000 + sram_addr[15:0])
                   : 16'hzzzz;

  // wrap instance: RESET_PC = 2^18-1, always ready
  fetch_if #(.AW(18), .DW(16)) wif ();
  logic        w_idle;
  logic [17:0] w_addr;
  wire  [15:0] w_data;
  logic        w_oe_n, w_we_n, w_en_n;

  fetch_unit #(.AW(18), .DW(16), .DEPTH(4), .WAIT_CYCLES(1), .RESET_PC(18'h3FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .ext_busy(ext_busy), .fetch_idle(w_idle), .out_if(wif),
    .sram_addr(w_addr), .sram_data(w_data), .sram_oe_n(w_oe_n),
    .sram_we_n(w_we_n), .sram_en_n(w_en_n)
  );

  assign w_data = (!w_oe_n && !w_en_n) ? 16'h1000 + w_addr[15:0] : 16'hzzzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    ext_busy = 1'b0;
    fif.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [17:0] exp_pc;
    logic        exp_oe_n;
    logic [17:0] exp_addr;
  } bp_vec_t;

  bp_vec_t bp[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, wn, last, first_pc;
    bit found, saw2, got;
    logic [17:0] wrap_exp_pc [2];

    wrap_exp_pc[0] = 18'h3FFFF;
    wrap_exp_pc[1] = 18'h00000;
    wif.ready = 1'b1;

    // edge:             ready valid pc  oe_n addr
    bp[0]  = '{1'b0, 1'b0, 18'd0, 1'b0, 18'd0};
    bp[1]  = '{1'b0, 1'b0, 18'd0, 1'b0, 18'd0};
    bp[2]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd1};
    bp[3]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd1};
    bp[4]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd2};
    bp[5]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd2};
    bp[6]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd3};
    bp[7]  = '{1'b0, 1'b1, 18'd0, 1'b0, 18'd3};
    bp[8]  = '{1'b0, 1'b1, 18'd0, 1'b1, 18'd3};
    bp[9]  = '{1'b0, 1'b1, 18'd0, 1'b1, 18'd3};
    bp[10] = '{1'b1, 1'b1, 18'd1, 1'b1, 18'd3};
    bp[11] = '{1'b0, 1'b1, 18'd1, 1'b0, 18'd4};
    bp[12] = '{1'b0, 1'b1, 18'd1, 1'b0, 18'd4};
    bp[13] = '{1'b0, 1'b1, 18'd1, 1'b1, 18'd4};
    bp[14] = '{1'b0, 1'b1, 18'd1, 1'b1, 18'd4};

    // ---- reset mid-read, then first-word latency ----
    zero_special = 1'b1;
    do_reset();
    tick();
    tick();
    check("pre_reset_oe_low", {31'd0, sram_oe_n}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_en_n", {31'd0, sram_en_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_idle", {31'd0, fetch_idle}, 32'd1);
    check("rst_valid", {31'd0, fif.valid}, 32'd0);
    check("rst_instr", {16'd0, fif.instr}, 32'd0);
    check("rst_pc", {14'd0, fif.pc}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("lat_valid_e2", {31'd0, fif.valid}, 32'd0);
    tick();
    check("lat_valid_e3", {31'd0, fif.valid}, 32'd1);
    check("lat_instr_e3", {16'd0, fif.instr}, 32'h0800);
    check("lat_pc_e3", {14'd0, fif.pc}, 32'd0);

    // ---- streaming + wrap instance ----
    zero_special = 1'b0;
    do_reset();
    fif.ready = 1'b1;
    n = 0; wn = 0; last = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (fif.valid && n < 4) begin
        check("stream_pc", {14'd0, fif.pc}, n);
        check("stream_instr", {16'd0, fif.instr}, 32'h1000 + n);
        if (n > 0) check("stream_spacing", cyc - last, 32'd2);
        last = cyc;
        n++;
      end
      if (wif.valid && wn < 2) begin
        check("wrap_pc", {14'd0, wif.pc}, {14'd0, wrap_exp_pc[wn]});
        check("wrap_instr", {16'd0, wif.instr}, {16'd0, 16'h1000 + wrap_exp_pc[wn][15:0]});
        wn++;
      end
      if (n == 4 && wn == 2) break;
    end
    check("stream_count", n, 32'd4);
    check("wrap_count", wn, 32'd2);

    // ---- backpressure vector table ----
    do_reset();
    for (int i = 0; i < 15; i++) begin
      fif.ready = bp[i].ready;
      tick();
      check($sformatf("bp%0d_valid", i), {31'd0, fif.valid}, {31'd0, bp[i].exp_valid});
      if (bp[i].exp_valid) begin
        check($sformatf("bp%0d_pc", i), {14'd0, fif.pc}, {14'd0, bp[i].exp_pc});
        check($sformatf("bp%0d_instr", i), {16'd0, fif.instr}, {16'd0, 16'h1000 + bp[i].exp_pc[15:0]});
      end
      check($sformatf("bp%0d_oe_n", i), {31'd0, sram_oe_n}, {31'd0, bp[i].exp_oe_n});
      check($sformatf("bp%0d_en_n", i), {31'd0, sram_en_n}, {31'd0, bp[i].exp_oe_n});
      check($sformatf("bp%0d_idle", i), {31'd0, fetch_idle}, {31'd0, bp[i].exp_oe_n});
      check($sformatf("bp%0d_addr", i), {14'd0, sram_addr}, {14'd0, bp[i].exp_addr});
    end

    // ---- redirect during read of address 2 ----
    do_reset();
    fif.ready = 1'b1;
    got = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (sram_addr == 18'd2 && !sram_oe_n) begin
        got = 1'b1;
        break;
      end
    end
    check("redir_reached_addr2", {31'd0, got}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 18'h00100;
    tick();
    redirect = 1'b0;
    check("redir_valid_after", {31'd0, fif.valid}, 32'd0);
    check("redir_oe_n_after", {31'd0, sram_oe_n}, 32'd1);
    check("redir_idle_after", {31'd0, fetch_idle}, 32'd1);
    found = 1'b0; saw2 = 1'b0; first_pc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (fif.valid) begin
        if (first_pc < 0) first_pc = int'(fif.pc);
        if (fif.pc == 18'd2) saw2 = 1'b1;
        if (fif.pc == 18'h00100 && !found) begin
          found = 1'b1;
          check("redir_instr", {16'd0, fif.instr}, 32'h1100);
        end
      end
      if (found) break;
    end
    check("redir_found_target", {31'd0, found}, 32'd1);
    check("redir_first_pc", first_pc, 32'h100);
    check("redir_no_word2", {31'd0, saw2}, 32'd0);

    // ---- bus yield ----
    do_reset();
    fif.ready = 1'b0;
    tick();
    check("yield_read_started", {31'd0, sram_oe_n}, 32'd0);
    ext_busy = 1'b1;
    tick();
    check("yield_inflight_oe", {31'd0, sram_oe_n}, 32'd0);
    tick();
    check("yield_done_valid", {31'd0, fif.valid}, 32'd1);
    check("yield_done_pc", {14'd0, fif.pc}, 32'd0);
    check("yield_done_idle", {31'd0, fetch_idle}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("yield_hold_oe", {31'd0, sram_oe_n}, 32'd1);
    end
    ext_busy = 1'b0;
    tick();
    check("yield_resume_oe", {31'd0, sram_oe_n}, 32'd0);
    check("yield_resume_addr", {14'd0, sram_addr}, 32'd1);
    check("yield_resume_idle", {31'd0, fetch_idle}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
